// File: rtl/clk_divider_multi_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int HALF_MIN  = 1;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  function automatic int chan_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic cnt_t default_half(cnt_t freq, cnt_t count);
    return freq / count;
  endfunction

endpackage

// File: rtl/clk_divider_multi_if.sv
// Config handshake bundle: target channel plus new half-period.
interface clk_divider_multi_if
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
);
  localparam int CH_W = chan_w(CHANNELS);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_half;

  modport master (output cfg_valid, cfg_chan, cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_divider_multi_chan.sv
// One divider channel: counter, active/shadow half-period and registered outputs.
module clk_div_chan #(
  parameter int               CNT_W    = 32,
  parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_start,
  input  logic             acc,
  input  logic [CNT_W-1:0] acc_half,
  output logic             pending,
  output logic             clk_div,
  output logic             tick
);

  logic [CNT_W-1:0] count, active_half, shadow;
  logic             at_end;

  // count never exceeds active_half-1, so equality is enough to wrap
  assign at_end = (count == active_half - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      clk_div     <= 1'b0;
      tick        <= 1'b0;
      active_half <= RST_HALF;
      shadow      <= RST_HALF;
      pending     <= 1'b0;
    end else begin
      if (sync_start) begin
        count   <= '0;
        clk_div <= 1'b0;
        tick    <= 1'b0;
        if (pending) begin
          active_half <= shadow;
          pending     <= 1'b0;
        end
      end else if (en) begin
        if (at_end) begin
          count   <= '0;
          clk_div <= ~clk_div;
          tick    <= 1'b1;
          if (pending) begin
            active_half <= shadow;
            pending     <= 1'b0;
          end
        end else begin
          count <= count + CNT_W'(1);
          tick  <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        // idle channel has no toggle boundary to wait for
        if (pending) begin
          active_half <= shadow;
          pending     <= 1'b0;
          count       <= '0;
        end
      end
      // accept only happens with pending clear, so it never races an apply
      if (acc) begin
        shadow  <= acc_half;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider top: decode, ready mux, channel array.
// Optional sticky config error flag when CLKDIV_ERR_EN is defined.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int DEFAULT_COUNT = 2,
  parameter int CHANNELS      = 4,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_start,
  clk_divider_multi_if.slave  cfg,
  output logic [CHANNELS-1:0] clk_div,
  output logic [CHANNELS-1:0] tick
`ifdef CLKDIV_ERR_EN
  ,
  output logic                cfg_err
`endif
);

  localparam int CH_W = chan_w(CHANNELS);
  localparam logic [CNT_W-1:0] DEFAULT_HALF =
    CNT_W'(default_half(cnt_t'(CLK_FREQ), cnt_t'(DEFAULT_COUNT)));

  logic [CHANNELS-1:0]    pending, sel;
  logic [(1<<CH_W)-1:0]   pend_ext;
  logic                   xfer;
  logic [CNT_W-1:0]       half_c;

  // unused decode slots read as not-pending, so out-of-range chans are ready
  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pending;
  end

  assign cfg.cfg_ready = ~pend_ext[cfg.cfg_chan];
  assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
  assign half_c        = (cfg.cfg_half == '0) ? CNT_W'(HALF_MIN) : cfg.cfg_half;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign sel[c] = (cfg.cfg_chan == CH_W'(c));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .RST_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[c]),
      .sync_start (sync_start),
      .acc        (xfer & sel[c]),
      .acc_half   (half_c),
      .pending    (pending[c]),
      .clk_div    (clk_div[c]),
      .tick       (tick[c])
    );
  end

`ifdef CLKDIV_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)
      cfg_err <= 1'b0;
    else if (xfer && ((cfg.cfg_half == '0) || ~|sel))
      cfg_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi (CLK_FREQ=8, DEFAULT_COUNT=2 -> half 4, 4 channels).
module tb_clk_divider_multi;
  logic       clk = 1'b0;
  logic       rst, sync_start;
  logic [3:0] en, clk_div, tick;
`ifdef CLKDIV_ERR_EN
  logic       cfg_err;
`endif
  int         n_chk = 0, n_err = 0;

  clk_divider_multi_if #(.CHANNELS(4), .CNT_W(8)) bus ();

  clk_divider_multi #(
    .CLK_FREQ(8), .DEFAULT_COUNT(2), .CHANNELS(4), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_start (sync_start),
    .cfg        (bus),
    .clk_div    (clk_div),
    .tick       (tick)
`ifdef CLKDIV_ERR_EN
    ,
    .cfg_err    (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] d, input logic [3:0] t);
    step();
    chk({tag, ".div"}, clk_div, d);
    chk({tag, ".tick"}, tick, t);
  endtask

  initial begin
    rst = 1'b1; en = 4'h0; sync_start = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_chan = 2'd0; bus.cfg_half = 8'd0;
    step(); step();
    chk("rst.div", clk_div, 4'h0);
    chk("rst.tick", tick, 4'h0);
    chk("rst.ready", bus.cfg_ready, 1'b1);
`ifdef CLKDIV_ERR_EN
    chk("rst.err", cfg_err, 1'b0);
`endif

    // default half-period 4: rise on 4th edge, fall on 8th
    rst = 1'b0; en = 4'hF;
    for (int k = 1; k <= 8; k++)
      step_chk($sformatf("a%0d", k), (k >= 4 && k < 8) ? 4'hF : 4'h0,
               (k == 4 || k == 8) ? 4'hF : 4'h0);

    // chan1 half=2 written at count=1
    step_chk("b9", 4'h0, 4'h0);
    bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd1; bus.cfg_half = 8'd2;
    #1 chk("b.rdy_pre", bus.cfg_ready, 1'b1);
    step_chk("b10", 4'h0, 4'h0);
    bus.cfg_valid = 1'b0;
    #1 chk("b.rdy10", bus.cfg_ready, 1'b0);
`ifdef CLKDIV_ERR_EN
    chk("b.err", cfg_err, 1'b0);
`endif
    step_chk("b11", 4'h0, 4'h0);
    chk("b.rdy11", bus.cfg_ready, 1'b0);
    step_chk("b12", 4'hF, 4'hF);
    chk("b.rdy12", bus.cfg_ready, 1'b1);
    step_chk("b13", 4'hF, 4'h0);
    step_chk("b14", 4'hD, 4'h2);
    step_chk("b15", 4'hD, 4'h0);
    step_chk("b16", 4'h2, 4'hF);

    // realign, then chan2 half=0 clamps to 1
    sync_start = 1'b1;
    step_chk("c17", 4'h0, 4'h0);
    sync_start = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd2; bus.cfg_half = 8'd0;
    step_chk("c18", 4'h0, 4'h0);
    bus.cfg_valid = 1'b0;
`ifdef CLKDIV_ERR_EN
    chk("c.err", cfg_err, 1'b1);
`endif
    step_chk("c19", 4'h2, 4'h2);
    step_chk("c20", 4'h2, 4'h0);
    step_chk("c21", 4'hD, 4'hF);
    step_chk("c22", 4'h9, 4'h4);
    step_chk("c23", 4'hF, 4'h6);
    step_chk("c24", 4'hB, 4'h4);

    // en[0] low 3 cycles at count=2 delays its toggle by 3
    sync_start = 1'b1;
    step();
    sync_start = 1'b0;
    chk("d25.div", clk_div, 4'h0);
    step(); chk("d26.div0", clk_div[0], 1'b0);
    step(); chk("d27.div0", clk_div[0], 1'b0);
    en = 4'b1110;
    for (int k = 28; k <= 30; k++) begin
      step();
      chk($sformatf("d%0d.div0", k), clk_div[0], 1'b0);
      chk($sformatf("d%0d.tick0", k), tick[0], 1'b0);
      if (k == 29) chk("d29.div3", clk_div[3], 1'b1);
    end
    en = 4'hF;
    step(); chk("d31.div0", clk_div[0], 1'b0);
    step();
    chk("d32.div0", clk_div[0], 1'b1);
    chk("d32.tick0", tick[0], 1'b1);
    chk("d32.div3", clk_div[3], 1'b1);

    // chan3 half=6 accepted on its own toggle edge, then sync applies it
    bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd3; bus.cfg_half = 8'd6;
    #1 chk("e.rdy_pre", bus.cfg_ready, 1'b1);
    step();
    chk("e33.div3", clk_div[3], 1'b0);
    chk("e33.tick3", tick[3], 1'b1);
    bus.cfg_valid = 1'b0;
    #1 chk("e33.rdy", bus.cfg_ready, 1'b0);
    sync_start = 1'b1;
    step_chk("e34", 4'h0, 4'h0);
    chk("e34.rdy", bus.cfg_ready, 1'b1);
    sync_start = 1'b0;
    for (int k = 35; k <= 40; k++) begin
      step();
      chk($sformatf("e%0d.div3", k), clk_div[3], (k == 40) ? 1'b1 : 1'b0);
      chk($sformatf("e%0d.tick3", k), tick[3], (k == 40) ? 1'b1 : 1'b0);
      chk($sformatf("e%0d.div0", k), clk_div[0], (k >= 38) ? 1'b1 : 1'b0);
    end

    // reset with a pending config and clk_div high
    bus.cfg_valid = 1'b1; bus.cfg_chan = 2'd0; bus.cfg_half = 8'd3;
    step();
    bus.cfg_valid = 1'b0;
    #1 chk("f41.rdy", bus.cfg_ready, 1'b0);
    chk("f41.div3", clk_div[3], 1'b1);
    rst = 1'b1;
    step_chk("f42", 4'h0, 4'h0);
    chk("f42.rdy", bus.cfg_ready, 1'b1);
`ifdef CLKDIV_ERR_EN
    chk("f42.err", cfg_err, 1'b0);
`endif
    rst = 1'b0;
    for (int k = 43; k <= 50; k++)
      step_chk($sformatf("f%0d", k), (k >= 46 && k < 50) ? 4'hF : 4'h0,
               (k == 46 || k == 50) ? 4'hF : 4'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
